// File: rtl/qam_frame_pkg.sv
// Shared definitions for the 16-QAM frame generator: state encoding,
// sym_type codes, preamble nibbles and the optional payload scrambler.
// Optional feature macro: FRAME_SCRAMBLER_EN (payload scrambler).
package qam_frame_pkg;

    // Frame sequencer states, kept as plain constants for legacy tools.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_PRE  = 3'd1;
    localparam state_t ST_SYNC = 3'd2;
    localparam state_t ST_HDR  = 3'd3;
    localparam state_t ST_PAY  = 3'd4;

    // Field codes reported on sym_type.
    localparam logic [1:0] TYPE_PRE  = 2'd0;
    localparam logic [1:0] TYPE_SYNC = 2'd1;
    localparam logic [1:0] TYPE_HDR  = 2'd2;
    localparam logic [1:0] TYPE_PAY  = 2'd3;

    // Preamble alternates between the two corner points, even index first.
    localparam logic [3:0] PRE_NIB_EVEN = 4'h0;
    localparam logic [3:0] PRE_NIB_ODD  = 4'hF;

`ifdef FRAME_SCRAMBLER_EN
    // Additive scrambler x^7 + x^4 + 1; taps select state bits 6 and 3.
    localparam logic [6:0] LFSR_SEED = 7'h7F;
    localparam logic [6:0] LFSR_TAPS = 7'b100_1000;

    typedef struct packed {
        logic [6:0] state;
        logic [3:0] nib;
    } scr_step_t;

    // Advance the scrambler by four bits; the first bit produced lands in the nibble MSB.
    function automatic scr_step_t lfsr_step4(input logic [6:0] s);
        scr_step_t r;
        logic      fb;
        r.state = s;
        r.nib   = '0;
        for (int i = 3; i >= 0; i--) begin
            fb       = ^(r.state & LFSR_TAPS);
            r.nib[i] = fb;
            r.state  = {r.state[5:0], fb};
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/sym_pack.sv
// Serial-to-nibble packer with a one-entry hold register. Bits are packed
// MSB-first; a finished group moves into the hold register, which the frame
// sequencer empties with take. A group completing in the same cycle as a
// take lands in the hold register, so no bit is lost.
module sym_pack (
    input  logic       clock,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       take,
    output logic       bit_ready,
    output logic       hold_full,
    output logic [3:0] hold_data
);

    logic [2:0] shift;
    logic [1:0] fill;
    logic       accept;
    logic       complete;

    // Stall only when the hold register is occupied and the fourth bit has nowhere to go.
    assign bit_ready = !(hold_full && fill == 2'd3);
    assign accept    = bit_valid && bit_ready;
    assign complete  = accept && fill == 2'd3;

    // Shift accepted bits in and hand finished groups to the hold register.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift     <= '0;
            fill      <= '0;
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            if (accept) begin
                shift <= {shift[1:0], bit_in};
                fill  <= fill + 2'd1;
            end
            if (complete) begin
                hold_data <= {shift, bit_in};
                hold_full <= 1'b1;
            end else if (take) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/frame_gen_16qam.sv
// 16-QAM frame generator: preamble, sync word, frame counter header and
// packed payload nibbles, advanced one symbol per sym_req.
// Optional feature macro: FRAME_SCRAMBLER_EN scrambles payload nibbles with
// an additive LFSR restarted at every frame.
module frame_gen_16qam #(
    parameter int          PRE_LEN   = 8,
    parameter int          PAY_LEN   = 64,
    parameter logic [15:0] SYNC_WORD = 16'hE25B
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic       sym_req,
    output logic [3:0] symbol,
    output logic       sym_valid,
    output logic [1:0] sym_type,
    output logic       frame_start,
    output logic       underrun
);
    import qam_frame_pkg::*;

    localparam logic [9:0] PRE_LAST = 10'(PRE_LEN - 1);
    localparam logic [9:0] PAY_LAST = 10'(PAY_LEN - 1);

    // state/cnt describe the symbol currently on the outputs.
    state_t     state;
    state_t     nxt_state;
    logic [9:0] cnt;
    logic [9:0] nxt_cnt;
    logic [7:0] frame_cnt;
    logic [3:0] nxt_symbol;
    logic [1:0] nxt_type;
    logic       nxt_first;
    logic       last_pay;
    logic       take;
    logic       hold_full;
    logic [3:0] hold_data;
    logic [3:0] pay_nib;

    sym_pack u_pack (
        .clock     (clock),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .take      (take),
        .bit_ready (bit_ready),
        .hold_full (hold_full),
        .hold_data (hold_data)
    );

    // Position of the symbol that the next sym_req will put on the outputs.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments, and every output gets a default first so no latch is inferred.
        nxt_state = state;
        nxt_cnt   = cnt + 10'd1;
        case (state)
            ST_IDLE: begin
                nxt_state = ST_PRE;
                nxt_cnt   = '0;
            end
            ST_PRE: if (cnt == PRE_LAST) begin
                nxt_state = ST_SYNC;
                nxt_cnt   = '0;
            end
            ST_SYNC: if (cnt == 10'd3) begin
                nxt_state = ST_HDR;
                nxt_cnt   = '0;
            end
            ST_HDR: if (cnt == 10'd1) begin
                nxt_state = ST_PAY;
                nxt_cnt   = '0;
            end
            ST_PAY: if (cnt == PAY_LAST) begin
                nxt_state = ST_PRE;
                nxt_cnt   = '0;
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    assign last_pay  = (state == ST_PAY) && (cnt == PAY_LAST);
    assign nxt_first = (nxt_state == ST_PRE) && (nxt_cnt == 10'd0);
    assign take      = sym_req && (nxt_state == ST_PAY);

`ifdef FRAME_SCRAMBLER_EN
    logic [6:0] scr_state;
    scr_step_t  scr_step;

    assign scr_step = lfsr_step4(scr_state);
    assign pay_nib  = hold_data ^ scr_step.nib;

    // Scrambler restarts with each frame and steps once per payload symbol, starved or not.
    always_ff @(posedge clock) begin
        if (reset) begin
            scr_state <= LFSR_SEED;
        end else if (sym_req) begin
            if (nxt_first) begin
                scr_state <= LFSR_SEED;
            end else if (nxt_state == ST_PAY) begin
                scr_state <= scr_step.state;
            end
        end
    end
`else
    assign pay_nib = hold_data;
`endif

    // Symbol value and field code for the next position.
    always_comb begin
        nxt_symbol = '0;
        nxt_type   = TYPE_PRE;
        case (nxt_state)
            ST_PRE: begin
                nxt_type   = TYPE_PRE;
                nxt_symbol = nxt_cnt[0] ? PRE_NIB_ODD : PRE_NIB_EVEN;
            end
            ST_SYNC: begin
                nxt_type = TYPE_SYNC;
                case (nxt_cnt[1:0])
                    2'd0:    nxt_symbol = SYNC_WORD[15:12];
                    2'd1:    nxt_symbol = SYNC_WORD[11:8];
                    2'd2:    nxt_symbol = SYNC_WORD[7:4];
                    default: nxt_symbol = SYNC_WORD[3:0];
                endcase
            end
            ST_HDR: begin
                nxt_type   = TYPE_HDR;
                nxt_symbol = nxt_cnt[0] ? frame_cnt[3:0] : frame_cnt[7:4];
            end
            ST_PAY: begin
                nxt_type   = TYPE_PAY;
                nxt_symbol = hold_full ? pay_nib : 4'h0;
            end
            default: begin
                nxt_type   = TYPE_PRE;
                nxt_symbol = '0;
            end
        endcase
    end

    // Register the sequencer and the outputs on each symbol request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            frame_cnt   <= '0;
            symbol      <= '0;
            sym_valid   <= 1'b0;
            sym_type    <= TYPE_PRE;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else if (sym_req) begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            symbol      <= nxt_symbol;
            sym_type    <= nxt_type;
            sym_valid   <= (nxt_state != ST_IDLE);
            frame_start <= nxt_first;
            if (last_pay) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (nxt_state == ST_PAY && !hold_full) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_gen_16qam.sv
// Self-checking bench for frame_gen_16qam. A frame-position model and a
// bit-level packer model predict every symbol when sym_req is driven; the
// prediction is queued and compared once the DUT registers its output.
// With FRAME_SCRAMBLER_EN defined the model also applies the payload scrambler.
module tb_frame_gen_16qam;

    localparam int          PRE_LEN   = 8;
    localparam int          PAY_LEN   = 64;
    localparam logic [15:0] SYNC      = 16'hE25B;
    localparam int          FRAME_LEN = PRE_LEN + 4 + 2 + PAY_LEN;

    logic       clock = 1'b0;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       sym_req;
    logic [3:0] symbol;
    logic       sym_valid;
    logic [1:0] sym_type;
    logic       frame_start;
    logic       underrun;

    frame_gen_16qam #(
        .PRE_LEN   (PRE_LEN),
        .PAY_LEN   (PAY_LEN),
        .SYNC_WORD (SYNC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .sym_req     (sym_req),
        .symbol      (symbol),
        .sym_valid   (sym_valid),
        .sym_type    (sym_type),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] sym;
        logic       valid;
        logic [1:0] typ;
        logic       fs;
        logic       und;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    // Reference model state.
    int         pos;
    int         frame_no;
    logic [3:0] grp_q[$];
    logic [3:0] build;
    int         nbits;
    logic       und_m;
    logic [8:0] pn;
    logic       bits_on;
    logic       zero_mode;
`ifdef FRAME_SCRAMBLER_EN
    logic [6:0] scr_m;
`endif

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s (frame %0d pos %0d): observed %0h expected %0h", tag, frame_no, pos, got, exp);
        end
    endtask

    // Predict the symbol produced by the next sym_req.
    task automatic model_sym(output exp_t e);
        logic [15:0] sw;
        logic [7:0]  fc;
        logic [3:0]  scr_nib;
        if (pos < 0) begin
            pos = 0;
        end else begin
            pos++;
            if (pos == FRAME_LEN) begin
                pos = 0;
                frame_no++;
            end
        end
        e.valid = 1'b1;
        e.fs    = (pos == 0);
        scr_nib = 4'h0;
`ifdef FRAME_SCRAMBLER_EN
        if (pos == 0) scr_m = 7'h7F;
`endif
        if (pos < PRE_LEN) begin
            e.typ = 2'd0;
            e.sym = (pos % 2 == 1) ? 4'hF : 4'h0;
        end else if (pos < PRE_LEN + 4) begin
            e.typ = 2'd1;
            sw    = SYNC;
            sw    = sw << (4 * (pos - PRE_LEN));
            e.sym = sw[15:12];
        end else if (pos < PRE_LEN + 6) begin
            e.typ = 2'd2;
            fc    = frame_no[7:0];
            e.sym = (pos == PRE_LEN + 4) ? fc[7:4] : fc[3:0];
        end else begin
            e.typ = 2'd3;
`ifdef FRAME_SCRAMBLER_EN
            for (int k = 0; k < 4; k++) begin
                scr_nib = {scr_nib[2:0], scr_m[6] ^ scr_m[3]};
                scr_m   = {scr_m[5:0], scr_m[6] ^ scr_m[3]};
            end
`endif
            if (grp_q.size() > 0) begin
                e.sym = grp_q.pop_front() ^ scr_nib;
            end else begin
                e.sym = 4'h0;
                und_m = 1'b1;
            end
        end
        e.und = und_m;
    endtask

    // One clock: drive inputs at the falling edge, compare just after the rising edge.
    task automatic cycle(input logic req);
        exp_t e;
        logic rdy_m;
        logic acc;
        @(negedge clock);
        rdy_m = !(grp_q.size() > 0 && nbits == 3);
        check("bit_ready", {15'd0, bit_ready}, {15'd0, rdy_m});
        bit_valid = bits_on;
        bit_in    = zero_mode ? 1'b0 : pn[8];
        sym_req   = req;
        acc       = bits_on && rdy_m;
        if (req) begin
            model_sym(e);
            sb.push_back(e);
        end
        if (acc) begin
            build = {build[2:0], bit_in};
            nbits++;
            if (nbits == 4) begin
                grp_q.push_back(build);
                nbits = 0;
            end
            pn = {pn[7:0], pn[8] ^ pn[4]};
        end
        @(posedge clock);
        #1;
        if (req) begin
            e = sb.pop_front();
            check("symbol",      {12'd0, symbol},      {12'd0, e.sym});
            check("sym_valid",   {15'd0, sym_valid},   {15'd0, e.valid});
            check("sym_type",    {14'd0, sym_type},    {14'd0, e.typ});
            check("frame_start", {15'd0, frame_start}, {15'd0, e.fs});
            check("underrun",    {15'd0, underrun},    {15'd0, e.und});
        end
    endtask

    task automatic run_syms(input int n, input int period);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1);
            for (int j = 1; j < period; j++) cycle(1'b0);
        end
    endtask

    // Assert reset for one edge, check the cleared outputs, then release.
    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        sym_req   = 1'b0;
        bit_valid = 1'b0;
        @(posedge clock);
        #1;
        pos      = -1;
        frame_no = 0;
        grp_q.delete();
        sb.delete();
        build    = 4'h0;
        nbits    = 0;
        und_m    = 1'b0;
        check("rst_symbol",      {12'd0, symbol},      16'h0);
        check("rst_sym_valid",   {15'd0, sym_valid},   16'h0);
        check("rst_sym_type",    {14'd0, sym_type},    16'h0);
        check("rst_frame_start", {15'd0, frame_start}, 16'h0);
        check("rst_underrun",    {15'd0, underrun},    16'h0);
        check("rst_bit_ready",   {15'd0, bit_ready},   16'h1);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        sym_req   = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        bits_on   = 1'b1;
        zero_mode = 1'b0;
        pn        = 9'h1FF;
        pos       = -1;
        frame_no  = 0;
        nbits     = 0;
        build     = 4'h0;
        und_m     = 1'b0;

        // Reset, then three frames with a continuous PN stream and sym_req every 8 clocks.
        do_reset();
        run_syms(3 * FRAME_LEN, 8);

        // Stop the bits partway through a payload: zeros, sticky underrun, same frame length.
        run_syms(PRE_LEN + 6 + 10, 8);
        bits_on = 1'b0;
        run_syms(20, 8);
        bits_on = 1'b1;
        run_syms(2 * FRAME_LEN - (PRE_LEN + 6 + 30), 8);

        // No sym_req: the packer fills and bit_ready drops after 7 accepted bits.
        do_reset();
        repeat (12) cycle(1'b0);

        // Symbol rates around the bit rate, so group completion and take coincide.
        run_syms(FRAME_LEN, 4);
        run_syms(FRAME_LEN, 3);
        run_syms(FRAME_LEN, 5);

        // Reset in the middle of a payload; next frame restarts at frame count 0.
        do_reset();
        run_syms(PRE_LEN + 6 + 20, 8);
        do_reset();
        run_syms(FRAME_LEN, 8);

        // Run through 256 frames so the header count wraps from FF to 00.
        do_reset();
        run_syms(256 * FRAME_LEN + PRE_LEN + 6, 1);

`ifdef FRAME_SCRAMBLER_EN
        // All-zero payload bits expose the scrambler sequence, restarting each frame.
        do_reset();
        zero_mode = 1'b1;
        run_syms(2 * FRAME_LEN, 8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_gen_16qam.md
FRAME_GEN_16QAM -- requirements
Module: frame_gen_16qam

Interface
REQ-001 SHALL have parameter PRE_LEN, default 8: preamble length in symbols (even, 2..254).
REQ-002 SHALL have parameter PAY_LEN, default 64: payload length in symbols (1..1023).
REQ-003 SHALL have parameter SYNC_WORD, default 16'hE25B: sync word sent MSB-nibble first.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port bit_in, input, 1, serial payload bit from the PN source.
REQ-007 SHALL have port bit_valid, input, 1, bit_in is qualified this cycle.
REQ-008 SHALL have port bit_ready, output, 1, the block can accept a bit this cycle.
REQ-009 SHALL have port sym_req, input, 1, one-cycle pulse from the shaping filter, once per symbol period.
REQ-010 SHALL have port symbol, output, 4, the current 16-QAM symbol index.
REQ-011 SHALL have port sym_valid, output, 1, symbol belongs to a frame (low in IDLE).
REQ-012 SHALL have port sym_type, output, 2, field of the current symbol: 0 preamble, 1 sync, 2 header, 3 payload.
REQ-013 SHALL have port frame_start, output, 1, pulse with the first preamble symbol of each frame.
REQ-014 SHALL have port underrun, output, 1, sticky flag for payload starvation.

Function
REQ-015 SHALL pack accepted bits MSB-first into 4-bit groups; a completed group moves to a one-entry hold register.
REQ-016 SHALL drive bit_ready = NOT (hold full AND 3 bits already packed); a bit is accepted when bit_valid AND bit_ready.
REQ-017 SHALL accept bits in every state, including IDLE, so that the hold register prefills.
REQ-018 SHALL advance only on sym_req; symbol, sym_valid, sym_type and frame_start are registered and update the cycle after sym_req, then hold until the next sym_req.
REQ-019 SHALL implement states IDLE -> PREAMBLE -> SYNC -> HEADER -> PAYLOAD -> PREAMBLE, with a symbol counter cleared on every state change.
REQ-020 SHALL leave IDLE on the first sym_req and emit preamble symbol 0 with frame_start = 1.
REQ-021 SHALL in PREAMBLE emit PRE_LEN symbols alternating 4'h0, 4'hF, starting with 4'h0.
REQ-022 SHALL in SYNC emit 4 symbols: SYNC_WORD[15:12], [11:8], [7:4], [3:0].
REQ-023 SHALL in HEADER emit 2 symbols: frame_cnt[7:4], then frame_cnt[3:0].
REQ-024 SHALL keep frame_cnt as an 8-bit counter incremented after the last payload symbol, wrapping 255 -> 0.
REQ-025 SHALL in PAYLOAD emit PAY_LEN symbols, each taken from the hold register on sym_req, emptying it.
REQ-026 SHALL on a payload sym_req with the hold register empty emit 4'h0, set underrun, and still advance the counter.
REQ-027 SHALL on a sym_req that empties the hold register in the same cycle a group completes load the new group with no bit lost.
REQ-028 SHALL after the last payload symbol go directly to PREAMBLE, with frame_start = 1 on the next sym_req.

Reset
REQ-029 SHALL on reset set state IDLE, counters 0, frame_cnt 0, packer and hold register empty, symbol 0, sym_valid 0, sym_type 0, frame_start 0, underrun 0.
REQ-030 SHALL on reset mid-frame discard partial bits and the current frame; the next frame starts with frame_cnt 0.
REQ-031 SHALL clear underrun only by reset.

Configuration
REQ-032 SHALL, with macro FRAME_SCRAMBLER_EN defined, XOR each payload nibble with 4 output bits of an additive LFSR x^7+x^4+1, seed 7'h7F, reloaded at each frame_start and stepped 4 bits per payload symbol, first output bit to symbol MSB.
REQ-033 SHALL, with FRAME_SCRAMBLER_EN undefined, pass payload unscrambled and contain no LFSR logic.

Structure
REQ-034 SHALL take the state enum, sym_type codes, preamble nibbles 4'h0/4'hF and the LFSR seed/taps from shared package qam_frame_pkg.
REQ-035 SHALL contain one sub-module, sym_pack: the bit packer plus hold register with the ready logic.

Verification
REQ-036 SHALL test: reset, a continuous PN bit stream, sym_req every 8 clocks -> symbols 0,F,0,F,0,F,0,F,E,2,5,B,0,0 then 64 payload nibbles, frame_start only on the first symbol.
REQ-037 SHALL test: three consecutive frames -> header nibbles 0,0 / 0,1 / 0,2; force frame_cnt = 255 -> next header 0,0.
REQ-038 SHALL test: bits stopped during payload -> 4'h0 emitted, underrun = 1 and stays 1; frame length stays unchanged.
REQ-039 SHALL test: bit_valid held high and sym_req held low -> bit_ready falls after 7 bits accepted; sym_req with a completing bit in the same cycle -> no nibble lost or duplicated.
REQ-040 SHALL test: reset asserted mid-payload -> next cycle state IDLE, all outputs 0; next frame header 0,0.
REQ-041 SHALL test: with FRAME_SCRAMBLER_EN and an all-zero bit stream -> payload equals the LFSR sequence from seed 7'h7F, restarting at every frame.
